// File: rtl/y_snapshot_serializer_pkg.sv
// Shared types and helpers for the y-bus snapshot serializer and its signature logic.
package y_ser_pkg;

   typedef enum logic {IDLE, SEND} ser_state_e;

   // Signature words are handled at a fixed maximum width; WORD_W must not exceed this.
   localparam int unsigned SIG_MAX_W = 64;
   typedef logic [SIG_MAX_W-1:0] sig_word_t;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

   function automatic int unsigned clog2_u(input int unsigned v);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic sig_word_t sig_update(input sig_word_t s, input sig_word_t w,
                                            input int unsigned width);
      sig_word_t mask;
      mask = (width >= SIG_MAX_W) ? '1 : ((sig_word_t'(1) << width) - sig_word_t'(1));
      return (((s << 1) | (s >> (width - 1))) ^ w) & mask;
   endfunction

endpackage

// File: rtl/y_snapshot_serializer_if.sv
// Valid/ready word stream leaving the snapshot serializer.
interface y_snapshot_serializer_if #(
   parameter int unsigned Y_WIDTH = 1390,
   parameter int unsigned WORD_W  = 32
);
   localparam int unsigned IDX_W = y_ser_pkg::clog2_u(y_ser_pkg::ceil_div(Y_WIDTH, WORD_W));

   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [WORD_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;

   modport master (output out_valid, out_data, out_last, out_idx, input out_ready);
   modport slave  (input out_valid, out_data, out_last, out_idx, output out_ready);
endinterface

// File: rtl/y_sig_accum.sv
// Rotate-left-1 XOR signature register with clear and update enables.
module y_sig_accum
   import y_ser_pkg::*;
#(
   parameter int unsigned WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              upd_i,
   input  logic [WORD_W-1:0] word_i,
   output logic [WORD_W-1:0] sig_o
);
   logic [WORD_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr_i) sig_d = '0;
      else if (upd_i) sig_d = WORD_W'(sig_update(sig_word_t'(sig_q), sig_word_t'(word_i), WORD_W));
   end

   always_ff @(posedge clk) begin
      if (rst) sig_q <= '0;
      else     sig_q <= sig_d;
   end

   assign sig_o = sig_q;
endmodule

// File: rtl/y_snapshot_serializer.sv
// Snapshots the wide y observation bus on capture and streams it out LSB word first.
module y_snapshot_serializer
   import y_ser_pkg::*;
#(
   parameter int unsigned Y_WIDTH = 1390,
   parameter int unsigned WORD_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [Y_WIDTH-1:0]       y_in,
   input  logic                     capture,
   y_snapshot_serializer_if.master  out,
   output logic                     busy,
   output logic [WORD_W-1:0]        sig,
   output logic                     sig_valid,
   output logic                     overrun
);
   localparam int unsigned NW       = ceil_div(Y_WIDTH, WORD_W);
   localparam int unsigned IDX_W    = clog2_u(NW);
   localparam int unsigned SNAP_W   = NW * WORD_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

   ser_state_e                   state_q;
   logic [NW-1:0][WORD_W-1:0]    snap_q;
   logic [NW-1:0][WORD_W-1:0]    y_words;
   logic [WORD_W-1:0]            data_q;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic                         last_q, sig_valid_q, overrun_q;
   logic                         handshake, accept;

   assign y_words   = SNAP_W'(y_in);
   assign idx_d     = idx_q + 1'b1;
   assign accept    = (state_q == IDLE) && capture;
   assign handshake = (state_q == SEND) && out.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         data_q      <= '0;
         idx_q       <= '0;
         last_q      <= 1'b0;
         sig_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sig_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (capture) begin
                  snap_q  <= y_words;
                  data_q  <= y_words[0];
                  idx_q   <= '0;
                  last_q  <= (NW == 1);
                  state_q <= SEND;
               end
            end
            SEND: begin
               // Capture on the final-handshake edge still counts as busy.
               if (capture) overrun_q <= 1'b1;
               if (out.out_ready) begin
                  if (last_q) begin
                     state_q     <= IDLE;
                     sig_valid_q <= 1'b1;
                  end else begin
                     idx_q  <= idx_d;
                     data_q <= snap_q[idx_d];
                     last_q <= (idx_d == LAST_IDX);
                  end
               end
            end
         endcase
      end
   end

   y_sig_accum #(.WORD_W(WORD_W)) u_sig (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (accept),
      .upd_i  (handshake),
      .word_i (data_q),
      .sig_o  (sig)
   );

   assign out.out_valid = (state_q == SEND);
   assign out.out_data  = data_q;
   assign out.out_idx   = idx_q;
   assign out.out_last  = last_q;
   assign busy          = (state_q == SEND);
   assign sig_valid     = sig_valid_q;
   assign overrun       = overrun_q;
endmodule

// File: tb/tb_y_snapshot_serializer.sv
// Randomized self-checking bench for y_snapshot_serializer (default and 70-bit instances).
module tb_y_snapshot_serializer;
   localparam int unsigned YA  = 1390;
   localparam int unsigned NWA = 44;
   localparam int unsigned YB  = 70;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [YA-1:0] y_a = '0;
   logic          cap_a = 1'b0;
   logic          busy_a, sigv_a, ovr_a;
   logic [31:0]   sig_a;
   logic [YB-1:0] y_b = '0;
   logic          cap_b = 1'b0;
   logic          busy_b, sigv_b, ovr_b;
   logic [31:0]   sig_b;

   y_snapshot_serializer_if #(.Y_WIDTH(YA), .WORD_W(32)) ifa ();
   y_snapshot_serializer_if #(.Y_WIDTH(YB), .WORD_W(32)) ifb ();

   y_snapshot_serializer #(.Y_WIDTH(YA), .WORD_W(32)) dut_a (
      .clk(clk), .rst(rst), .y_in(y_a), .capture(cap_a), .out(ifa.master),
      .busy(busy_a), .sig(sig_a), .sig_valid(sigv_a), .overrun(ovr_a)
   );
   y_snapshot_serializer #(.Y_WIDTH(YB), .WORD_W(32)) dut_b (
      .clk(clk), .rst(rst), .y_in(y_b), .capture(cap_b), .out(ifb.master),
      .busy(busy_b), .sig(sig_b), .sig_valid(sigv_b), .overrun(ovr_b)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_words;
   bit          exp_ovr = 1'b0;
   logic [31:0] obs_w [NWA];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference: bus zero-extended to whole words, word k is bits [32k+31:32k].
   function automatic logic [31:0] ref_word(input logic [YA-1:0] v, input int unsigned k);
      logic [NWA*32-1:0] p;
      p = '0;
      p[YA-1:0] = v;
      return 32'(p >> (k * 32));
   endfunction

   function automatic logic [31:0] rotl1(input logic [31:0] s);
      return (s << 1) | (s >> 31);
   endfunction

   function automatic logic [YA-1:0] rand_y();
      logic [NWA*32-1:0] t;
      for (int i = 0; i < NWA; i++) t[i*32 +: 32] = $urandom();
      return t[YA-1:0];
   endfunction

   // Starts at a negedge with the DUT idle; ends at the negedge where sig_valid is expected.
   task automatic stream_a(input logic [YA-1:0] yv, input int unsigned rmode, input bit scramble,
                           input int cap_word, input bit cap_final);
      logic [31:0] rs;
      int unsigned exp_idx, cyc;
      bit rdy, done, inj, injected;
      y_a = yv; cap_a = 1'b1; ifa.out_ready = 1'b0;
      rs = '0; exp_idx = 0; cyc = 0; done = 1'b0; injected = 1'b0; n_words = 0;
      @(negedge clk);
      cap_a = 1'b0;
      while (!done && cyc < 400) begin
         if (scramble) y_a = rand_y();
         chk("valid", {63'd0, ifa.out_valid}, 64'd1);
         chk("busy", {63'd0, busy_a}, 64'd1);
         chk("idx", 64'(ifa.out_idx), 64'(exp_idx));
         chk("data", 64'(ifa.out_data), 64'(ref_word(yv, exp_idx)));
         chk("last", {63'd0, ifa.out_last}, {63'd0, exp_idx == NWA - 1});
         chk("sigv_low", {63'd0, sigv_a}, 64'd0);
         chk("overrun", {63'd0, ovr_a}, {63'd0, exp_ovr});
         obs_w[exp_idx] = ifa.out_data;
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         inj = (!injected && cap_word >= 0 && exp_idx == cap_word) ||
               (cap_final && rdy && exp_idx == NWA - 1);
         if (inj) begin
            injected = 1'b1;
            y_a = ~yv;
         end
         cap_a = inj;
         ifa.out_ready = rdy;
         @(negedge clk);
         cap_a = 1'b0;
         if (inj) exp_ovr = 1'b1;
         cyc++;
         if (rdy) begin
            rs = rotl1(rs) ^ ref_word(yv, exp_idx);
            n_words++;
            if (exp_idx == NWA - 1) done = 1'b1;
            else exp_idx++;
         end
      end
      ifa.out_ready = 1'b0;
      if (!done) chk("stream_timeout", 64'd0, 64'd1);
      chk("sig_valid", {63'd0, sigv_a}, 64'd1);
      chk("sig_final", 64'(sig_a), 64'(rs));
      chk("end_valid", {63'd0, ifa.out_valid}, 64'd0);
      chk("end_busy", {63'd0, busy_a}, 64'd0);
      chk("end_overrun", {63'd0, ovr_a}, {63'd0, exp_ovr});
      chk("word_count", 64'(n_words), 64'(NWA));
   endtask

   initial begin
      logic [NWA*32-1:0] asc;
      logic [YA-1:0] yv;
      int unsigned guard;

      // Reset held with capture and ready asserted: reset must win.
      cap_a = 1'b1; cap_b = 1'b1; ifa.out_ready = 1'b1; ifb.out_ready = 1'b1; y_a = '1;
      repeat (3) @(negedge clk);
      chk("rst_valid", {63'd0, ifa.out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy_a}, 64'd0);
      chk("rst_data", 64'(ifa.out_data), 64'd0);
      chk("rst_idx", 64'(ifa.out_idx), 64'd0);
      chk("rst_last", {63'd0, ifa.out_last}, 64'd0);
      chk("rst_sig", 64'(sig_a), 64'd0);
      chk("rst_sigv", {63'd0, sigv_a}, 64'd0);
      chk("rst_ovr", {63'd0, ovr_a}, 64'd0);
      chk("rst_b_valid", {63'd0, ifb.out_valid}, 64'd0);
      cap_a = 1'b0; cap_b = 1'b0; ifa.out_ready = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // 70-bit instance, all ones, ready held high.
      y_b = '1; cap_b = 1'b1; ifb.out_ready = 1'b1;
      @(negedge clk);
      cap_b = 1'b0;
      chk("b_w0", 64'(ifb.out_data), 64'hFFFFFFFF);
      chk("b_l0", {63'd0, ifb.out_last}, 64'd0);
      @(negedge clk);
      chk("b_w1", 64'(ifb.out_data), 64'hFFFFFFFF);
      chk("b_l1", {63'd0, ifb.out_last}, 64'd0);
      @(negedge clk);
      chk("b_w2", 64'(ifb.out_data), 64'h0000003F);
      chk("b_l2", {63'd0, ifb.out_last}, 64'd1);
      chk("b_idx2", 64'(ifb.out_idx), 64'd2);
      @(negedge clk);
      chk("b_sigv", {63'd0, sigv_b}, 64'd1);
      chk("b_sig", 64'(sig_b), 64'h3F);
      chk("b_valid_end", {63'd0, ifb.out_valid}, 64'd0);
      @(negedge clk);
      chk("b_sigv_pulse", {63'd0, sigv_b}, 64'd0);
      chk("b_sig_hold", 64'(sig_b), 64'h3F);
      ifb.out_ready = 1'b0;

      // Ascending byte pattern, full rate then 1,0,0 backpressure.
      for (int k = 0; k < NWA * 4; k++) asc[k*8 +: 8] = 8'(k % 256);
      yv = asc[YA-1:0];
      stream_a(yv, 0, 1'b0, -1, 1'b0);
      chk("asc_w0", 64'(obs_w[0]), 64'h03020100);
      chk("asc_w43", 64'(obs_w[NWA-1]), 64'h00002DAC);
      stream_a(yv, 1, 1'b0, -1, 1'b0);

      // Captures during the stream and on the final edge, then one in the sig_valid cycle.
      stream_a(rand_y(), 2, 1'b0, 2, 1'b1);
      stream_a(rand_y(), 0, 1'b0, -1, 1'b0);
      stream_a(rand_y(), 2, 1'b1, -1, 1'b0);

      // Reset together with ready at word 10.
      y_a = rand_y(); cap_a = 1'b1;
      @(negedge clk);
      cap_a = 1'b0; ifa.out_ready = 1'b1;
      guard = 0;
      while (ifa.out_idx != 6'd10 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) chk("rst_wait_timeout", 64'd0, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; ifa.out_ready = 1'b0; exp_ovr = 1'b0;
      chk("mid_rst_valid", {63'd0, ifa.out_valid}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy_a}, 64'd0);
      chk("mid_rst_sig", 64'(sig_a), 64'd0);
      chk("mid_rst_idx", 64'(ifa.out_idx), 64'd0);
      chk("mid_rst_sigv", {63'd0, sigv_a}, 64'd0);
      chk("mid_rst_ovr", {63'd0, ovr_a}, 64'd0);
      @(negedge clk);
      chk("mid_rst_sigv2", {63'd0, sigv_a}, 64'd0);
      stream_a(rand_y(), 0, 1'b0, -1, 1'b0);

      for (int r = 0; r < 3; r++) stream_a(rand_y(), 2, 1'($urandom_range(0, 1)), -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
